usb_cmd_rx: RTL

Host-to-FPGA command receiver for the FX2 slave-FIFO interface, clocked by the 48 MHz USB interface clock. It pulls 16-bit words from the FX2 OUT endpoint (EP2) through a read strobe sequence and parses them into framed commands. Each complete frame is presented as an 8-bit command code with a 32-bit parameter and a one-cycle strobe, for use by the system-side control logic. It shares the slave-FIFO bus with the upload writer through a request/grant pair and drives the bus only while granted.

---
 rtl/usb_cmd_rx_if.sv | 30 +++
 rtl/usb_cmd_rx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_rx_if.sv
// FX2 slave-FIFO bus bundle shared between usb_cmd_rx and the FX2 side.
//   i_flag_empty_n : EP2 empty flag, 0 = empty
//   i_data         : FD bus input half (16 bit)
//   i_bus_grant    : bus grant from the upload writer
//   o_bus_req      : bus request
//   o_bus_own      : receiver currently drives the FIFO control pins
//   o_addr         : FIFOADR
//   o_slcs/o_sloe/o_slrd : chip select / output enable / read strobe, active low
// master = receiver side, slave = FX2/arbiter side.
interface usb_cmd_rx_if;
  logic        i_flag_empty_n;
  logic [15:0] i_data;
  logic        i_bus_grant;
  logic        o_bus_req;
  logic        o_bus_own;
  logic [1:0]  o_addr;
  logic        o_slcs;
  logic        o_sloe;
  logic        o_slrd;

  modport master (
    input  i_flag_empty_n, i_data, i_bus_grant,
    output o_bus_req, o_bus_own, o_addr, o_slcs, o_sloe, o_slrd
  );

  modport slave (
    output i_flag_empty_n, i_data, i_bus_grant,
    input  o_bus_req, o_bus_own, o_addr, o_slcs, o_sloe, o_slrd
  );
endinterface

// File: rtl/usb_cmd_rx.sv
// usb_cmd_rx: pulls 16-bit words from FX2 EP2 OUT and parses framed commands.
//   Frame: SYNC_WORD, {~code, code}, param[15:0], param[31:16].
// Ports:
//   i_clk_usb   : 48 MHz USB interface clock (only clock)
//   i_rst       : synchronous active-high reset
//   fx2         : slave-FIFO bus (usb_cmd_rx_if.master)
//   o_cmd       : last decoded command code
//   o_cmd_param : last decoded 32-bit parameter
//   o_cmd_come  : one-cycle strobe, new o_cmd/o_cmd_param
//   o_err       : one-cycle strobe, complement-check failure or timeout
// Build option: define USB_CMD_CHECK_EN to enable the {~code, code} check on
// word1; without it the high byte of word1 is ignored.
module usb_cmd_rx #(
  parameter int          TIMEOUT_CYCLES = 48000,
  parameter logic [15:0] SYNC_WORD      = 16'hA55A,
  parameter logic [1:0]  EP_ADDR        = 2'b00
) (
  input  logic               i_clk_usb,
  input  logic               i_rst,
  usb_cmd_rx_if.master       fx2,
  output logic [7:0]         o_cmd,
  output logic [31:0]        o_cmd_param,
  output logic               o_cmd_come,
  output logic               o_err
);

  typedef enum logic [2:0] {B_IDLE, B_SEL, B_OE, B_RD, B_REL} bus_st_e;
  typedef enum logic [1:0] {P_HUNT, P_CMD, P_PL, P_PH} prs_st_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  bus_st_e     bus_q, bus_d;
  logic        req_q, req_d, own_q, own_d;
  logic        slcs_q, slcs_d, sloe_q, sloe_d, slrd_q, slrd_d;
  logic [1:0]  addr_q, addr_d;

  prs_st_e     ps_q, ps_d;
  logic [7:0]  code_q, code_d;
  logic [15:0] plo_q, plo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] param_q, param_d;
  logic        come_q, come_d, err_q, err_d;

  // The RD cycle is the one where slrd is low; FD is sampled at its closing edge.
  logic        word_stb;
  logic [15:0] word;
  assign word_stb = (bus_q == B_RD);
  assign word     = fx2.i_data;

  always_comb begin
    bus_d = bus_q;
    unique case (bus_q)
      B_IDLE:  if (fx2.i_bus_grant && fx2.i_flag_empty_n) bus_d = B_SEL;
      B_SEL:   bus_d = B_OE;
      B_OE:    bus_d = fx2.i_flag_empty_n ? B_RD : B_REL;
      B_RD:    bus_d = B_REL;
      B_REL:   bus_d = B_IDLE;
      default: bus_d = B_IDLE;
    endcase
    // Pin levels are decoded from the next state so every pin is a flop
    // that matches the state it belongs to.
    req_d  = (bus_d == B_IDLE) && fx2.i_flag_empty_n;
    own_d  = (bus_d != B_IDLE);
    slcs_d = (bus_d == B_IDLE);
    sloe_d = !((bus_d == B_OE) || (bus_d == B_RD));
    slrd_d = (bus_d != B_RD);
    addr_d = own_d ? EP_ADDR : 2'b00;
  end

  always_comb begin
    ps_d    = ps_q;
    code_d  = code_q;
    plo_d   = plo_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    param_d = param_q;
    come_d  = 1'b0;
    err_d   = 1'b0;
    if (word_stb) begin
      cnt_d = '0;
      case (ps_q)
        P_HUNT: if (word == SYNC_WORD) ps_d = P_CMD;
        P_CMD: begin
          code_d = word[7:0];
          ps_d   = P_PL;
`ifdef USB_CMD_CHECK_EN
          if (word[15:8] != ~word[7:0]) begin
            ps_d  = P_HUNT;
            err_d = 1'b1;
          end
`endif
        end
        P_PL: begin
          plo_d = word;
          ps_d  = P_PH;
        end
        P_PH: begin
          cmd_d   = code_q;
          param_d = {word, plo_q};
          come_d  = 1'b1;
          ps_d    = P_HUNT;
        end
      endcase
    end else if (ps_q != P_HUNT) begin
      // A captured word always wins over the timeout on the same cycle.
      if (cnt_q == TO_LAST) begin
        ps_d  = P_HUNT;
        err_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk_usb) begin
    if (i_rst) begin
      bus_q   <= B_IDLE;
      req_q   <= 1'b0;
      own_q   <= 1'b0;
      slcs_q  <= 1'b1;
      sloe_q  <= 1'b1;
      slrd_q  <= 1'b1;
      addr_q  <= 2'b00;
      ps_q    <= P_HUNT;
      code_q  <= '0;
      plo_q   <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      param_q <= '0;
      come_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      req_q   <= req_d;
      own_q   <= own_d;
      slcs_q  <= slcs_d;
      sloe_q  <= sloe_d;
      slrd_q  <= slrd_d;
      addr_q  <= addr_d;
      ps_q    <= ps_d;
      code_q  <= code_d;
      plo_q   <= plo_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      param_q <= param_d;
      come_q  <= come_d;
      err_q   <= err_d;
    end
  end

  assign fx2.o_bus_req = req_q;
  assign fx2.o_bus_own = own_q;
  assign fx2.o_addr    = addr_q;
  assign fx2.o_slcs    = slcs_q;
  assign fx2.o_sloe    = sloe_q;
  assign fx2.o_slrd    = slrd_q;
  assign o_cmd         = cmd_q;
  assign o_cmd_param   = param_q;
  assign o_cmd_come    = come_q;
  assign o_err         = err_q;

endmodule
